// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
package mips_loader_pkg;

    localparam int LEN_W      = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mips_imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
interface mips_imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Host side: drives the byte stream, observes the memory writes.
    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes the byte stream, drives the memory writes.
    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_imem_loader_word_pack.sv
// Packs accepted data bytes into big-endian 32-bit words and keeps a running
// XOR checksum over every data byte of the image.
module loader_word_pack
    import mips_loader_pkg::*;
(
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  bcnt;
    logic [23:0] sr;
    logic [7:0]  acc;

    // The word completes combinationally with its 4th byte so the top can
    // register the write strobe on the same edge that accepts the byte.
    assign word_valid = byte_vld && (bcnt == 2'(WORD_BYTES - 1));
    assign word       = {sr, byte_in};
    assign csum       = acc;

    // Byte counter, shift register and checksum accumulator.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            sr   <= '0;
            acc  <= '0;
        end else if (clr) begin
            bcnt <= '0;
            sr   <= '0;
            acc  <= '0;
        end else if (byte_vld) begin
            bcnt <= bcnt + 2'd1;
            sr   <= {sr[15:0], byte_in};
            acc  <= acc ^ byte_in;
        end
    end

endmodule

// File: rtl/mips_imem_loader.sv
// Framed byte-stream boot loader: writes the image into instruction memory
// from word 0, holds the core while loading and releases it with a start
// pulse once the checksum matches.
module mips_imem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    mips_imem_loader_if.slave bus,
    input  logic              reload,
    output logic              core_hold,
    output logic              core_start,
    output logic              load_err,
    output logic [LEN_W-1:0]  words_loaded
);

    state_t            state, state_nxt;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  n_len;
    logic [LEN_W-1:0]  len_nxt;
    logic [ADDR_W:0]   widx;       // one extra bit so N = 2**ADDR_W fits
    logic [LEN_W-1:0]  wcnt;
    logic              acc_byte;
    logic              data_acc;
    logic              restart;
    logic              last_word;
    logic              csum_ok;
    logic              word_valid;
    logic [31:0]       word;
    logic [7:0]        csum;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              start_q;

    assign bus.s_ready = (state == IDLE) || (state == LEN_LO) ||
                         (state == DATA) || (state == CSUM);
    assign acc_byte    = bus.s_valid && bus.s_ready;
    assign data_acc    = acc_byte && (state == DATA);
    assign restart     = reload && ((state == DONE) || (state == ERR));
    assign len_nxt     = {len_hi, bus.s_data};
    assign last_word   = word_valid && ((32'(widx) + 32'd1) == 32'(n_len));
    assign csum_ok     = (bus.s_data == csum);

    assign core_hold    = (state != DONE);
    assign load_err     = (state == ERR);
    assign core_start   = start_q;
    assign words_loaded = wcnt;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    loader_word_pack u_pack (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .clr        (restart),
        .byte_vld   (data_acc),
        .byte_in    (bus.s_data),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode from byte acceptance, length and checksum.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (acc_byte) state_nxt = LEN_LO;
            LEN_LO: if (acc_byte) begin
                        if (32'(len_nxt) > (32'd1 << ADDR_W)) state_nxt = ERR;
                        else if (len_nxt == '0)                state_nxt = CSUM;
                        else                                   state_nxt = DATA;
                    end
            DATA:   if (last_word) state_nxt = CSUM;
            CSUM:   if (acc_byte) state_nxt = csum_ok ? DONE : ERR;
            DONE,
            ERR:    if (restart) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Length capture from the two header bytes.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            len_hi <= '0;
            n_len  <= '0;
        end else if (acc_byte && (state == IDLE)) begin
            len_hi <= bus.s_data;
        end else if (acc_byte && (state == LEN_LO)) begin
            n_len <= len_nxt;
        end
    end

    // Word index and loaded-word count, cleared when a new image is requested.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            widx <= '0;
            wcnt <= '0;
        end else if (restart) begin
            widx <= '0;
            wcnt <= '0;
        end else if (word_valid) begin
            widx <= widx + 1'b1;
            wcnt <= wcnt + 1'b1;
        end
    end

    // Registered memory write and start pulse.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            we_q    <= word_valid;
            start_q <= acc_byte && (state == CSUM) && csum_ok;
            if (word_valid) begin
                addr_q  <= widx[ADDR_W-1:0];
                wdata_q <= word;
            end
        end
    end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for the instruction-memory boot loader.
module tb_mips_imem_loader;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        reload = 1'b0;
    logic        core_hold;
    logic        core_start;
    logic        load_err;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [31:0] img     [0:1023];
    logic [9:0]  wr_addr [0:2047];
    logic [31:0] wr_data [0:2047];
    int          wr_cnt = 0;
    int          st_cnt = 0;

    mips_imem_loader_if #(.ADDR_W(10)) bus ();

    mips_imem_loader #(.ADDR_W(10)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .bus          (bus),
        .reload       (reload),
        .core_hold    (core_hold),
        .core_start   (core_start),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk1 = ~clk1;

    // Record memory writes and start pulses away from the active edge.
    always @(negedge clk1) begin
        if (bus.mem_we && wr_cnt < 2048) begin
            wr_addr[wr_cnt] = bus.mem_addr;
            wr_data[wr_cnt] = bus.mem_wdata;
            wr_cnt++;
        end
        if (core_start) st_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit done;
        done = 1'b0;
        repeat (gap) @(negedge clk1);
        @(negedge clk1);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.s_ready) begin
                @(posedge clk1);
                done = 1'b1;
            end else begin
                @(negedge clk1);
            end
        end
        if (!done) check("accept_timeout", 32'(done), 32'd1);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic send_body(input logic [15:0] len, input int nw, input int gap);
        logic [31:0] w;
        send(len[15:8], gap);
        send(len[7:0], gap);
        for (int i = 0; i < nw; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) send(w[31-8*k -: 8], gap);
        end
    endtask

    function automatic logic [7:0] csum_of(input int nw);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < nw; i++)
            c = c ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
        return c;
    endfunction

    // Called right after the checksum-accept edge.
    task automatic check_start(input string tag);
        @(negedge clk1);
        check({tag, "_start_hi"}, 32'(core_start), 32'd1);
        check({tag, "_hold_lo"},  32'(core_hold),  32'd0);
        @(negedge clk1);
        check({tag, "_start_lo"}, 32'(core_start), 32'd0);
        check({tag, "_hold_stay"}, 32'(core_hold), 32'd0);
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk1);
        reload = 1'b1;
        @(posedge clk1);
        #1 reload = 1'b0;
        @(negedge clk1);
        check({tag, "_rl_ready"}, 32'(bus.s_ready),  32'd1);
        check({tag, "_rl_err"},   32'(load_err),     32'd0);
        check({tag, "_rl_hold"},  32'(core_hold),    32'd1);
        check({tag, "_rl_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus.s_ready),   32'd1);
        check({tag, "_hold"},  32'(core_hold),     32'd1);
        check({tag, "_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "_start"}, 32'(core_start),    32'd0);
        check({tag, "_err"},   32'(load_err),      32'd0);
        check({tag, "_words"}, 32'(words_loaded),  32'd0);
    endtask

    initial begin
        int base, sbase;
        logic [31:0] prog [0:8];
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // Reset state
        #12;
        check_reset_vals("rst");
        @(negedge clk1);
        rst_n = 1'b1;

        // Nine-word add program, back-to-back bytes
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        for (int i = 0; i < 9; i++) img[i] = prog[i];
        base = wr_cnt; sbase = st_cnt;
        send_body(16'd9, 9, 0);
        send(csum_of(9), 0);
        check_start("add9");
        check("add9_nwr", 32'(wr_cnt - base), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("add9_addr%0d", i), 32'(wr_addr[base+i]), 32'(i));
            check($sformatf("add9_data%0d", i), wr_data[base+i], prog[i]);
        end
        check("add9_words", 32'(words_loaded), 32'd9);
        check("add9_nstart", 32'(st_cnt - sbase), 32'd1);
        check("add9_done_ready", 32'(bus.s_ready), 32'd0);
        do_reload("add9");

        // Single word with 3 idle cycles between every byte
        img[0] = 32'hfc000000;
        base = wr_cnt;
        send_body(16'd1, 1, 3);
        send(8'hfc, 3);
        check_start("gap");
        check("gap_nwr",  32'(wr_cnt - base), 32'd1);
        check("gap_addr", 32'(wr_addr[base]), 32'd0);
        check("gap_data", wr_data[base], 32'hfc000000);
        do_reload("gap");

        // Bad checksum
        sbase = st_cnt;
        send_body(16'd1, 1, 0);
        send(8'hfd, 0);
        @(negedge clk1);
        check("bad_err",   32'(load_err),    32'd1);
        check("bad_hold",  32'(core_hold),   32'd1);
        check("bad_ready", 32'(bus.s_ready), 32'd0);
        check("bad_start", 32'(core_start),  32'd0);
        @(negedge clk1);
        check("bad_nstart", 32'(st_cnt - sbase), 32'd0);
        do_reload("bad");

        // Zero length, good then bad checksum
        base = wr_cnt;
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        check_start("zero");
        check("zero_nwr", 32'(wr_cnt - base), 32'd0);
        do_reload("zero");
        sbase = st_cnt;
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
        @(negedge clk1);
        check("zero_bad_err", 32'(load_err), 32'd1);
        check("zero_bad_nstart", 32'(st_cnt - sbase), 32'd0);
        do_reload("zero_bad");

        // Oversized length 0x0401
        base = wr_cnt;
        send(8'h04, 0); send(8'h01, 0);
        @(negedge clk1);
        check("big_err",   32'(load_err),    32'd1);
        check("big_ready", 32'(bus.s_ready), 32'd0);
        check("big_nwr",   32'(wr_cnt - base), 32'd0);
        do_reload("big");

        // Maximum length 0x0400
        for (int i = 0; i < 1024; i++) img[i] = (32'(i) * 32'h01010101) ^ 32'hdeadbeef;
        base = wr_cnt;
        send_body(16'h0400, 1024, 0);
        send(csum_of(1024), 0);
        check_start("max");
        check("max_nwr",   32'(wr_cnt - base), 32'd1024);
        check("max_last",  32'(wr_addr[base+1023]), 32'd1023);
        check("max_words", 32'(words_loaded), 32'd1024);
        for (int i = 0; i < 1024; i++)
            if (wr_data[base+i] !== img[i] || wr_addr[base+i] !== 10'(i))
                check($sformatf("max_word%0d", i), wr_data[base+i], img[i]);
        do_reload("max");

        // Reset after 2 of 3 words
        img[0] = 32'h11223344; img[1] = 32'h55667788; img[2] = 32'h99aabbcc;
        sbase = st_cnt;
        send_body(16'd3, 2, 0);
        @(negedge clk1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        check("midrst_nstart", 32'(st_cnt - sbase), 32'd0);
        base = wr_cnt;
        send_body(16'd3, 3, 0);
        send(csum_of(3), 0);
        check_start("post");
        check("post_nwr", 32'(wr_cnt - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_addr%0d", i), 32'(wr_addr[base+i]), 32'(i));
            check($sformatf("post_data%0d", i), wr_data[base+i], img[i]);
        end
        check("post_words", 32'(words_loaded), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
